// File: rtl/rf_master.sv
// Command-driven controller sequencing the read/write ports of an 8x8 register file.
// Optional address range checking is enabled by defining RF_MASTER_ADDR_CHECK_EN.
module rf_master #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [SEL_W-1:0]  cmd_addr,
  input  logic [SEL_W-1:0]  cmd_dst,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              err,
  output logic [SEL_W-1:0]  rf_rd_sel,
  output logic [SEL_W-1:0]  rf_wr_sel,
  output logic              rf_wr_en,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [DATA_W-1:0] rf_data_out
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RESP,
    S_WR,
    S_CLR
  } state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                err_q, err_d;
  logic [SEL_W-1:0]    rf_rd_sel_q, rf_rd_sel_d;
  logic [SEL_W-1:0]    rf_wr_sel_q, rf_wr_sel_d;
  logic                rf_wr_en_q, rf_wr_en_d;
  logic [DATA_W-1:0]   rf_data_in_q, rf_data_in_d;
  logic                is_copy_q, is_copy_d;
  logic [SEL_W-1:0]    dst_q, dst_d;
  logic                bad_q, bad_d;
  logic [SEL_W-1:0]    cnt_q, cnt_d;
  logic                acc_bad_c;

  // Out-of-range address flag for the command being offered this cycle.
`ifdef RF_MASTER_ADDR_CHECK_EN
  assign acc_bad_c = (cmd_op != OP_CLEAR) &&
                     ((cmd_addr >= SEL_W'(NUM_REGS)) ||
                      ((cmd_op == OP_COPY) && (cmd_dst >= SEL_W'(NUM_REGS))));
`else
  assign acc_bad_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      err_q        <= 1'b0;
      rf_rd_sel_q  <= '0;
      rf_wr_sel_q  <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_data_in_q <= '0;
      is_copy_q    <= 1'b0;
      dst_q        <= '0;
      bad_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      err_q        <= err_d;
      rf_rd_sel_q  <= rf_rd_sel_d;
      rf_wr_sel_q  <= rf_wr_sel_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_data_in_q <= rf_data_in_d;
      is_copy_q    <= is_copy_d;
      dst_q        <= dst_d;
      bad_q        <= bad_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic; port values are computed for the state being entered.
  always_comb begin
    state_d      = state_q;
    rsp_data_d   = rsp_data_q;
    err_d        = err_q;
    rf_rd_sel_d  = rf_rd_sel_q;
    rf_wr_sel_d  = rf_wr_sel_q;
    rf_wr_en_d   = 1'b0;
    rf_data_in_d = rf_data_in_q;
    is_copy_d    = is_copy_q;
    dst_d        = dst_q;
    bad_d        = bad_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          bad_d     = acc_bad_c;
          err_d     = err_q | acc_bad_c;
          dst_d     = cmd_dst;
          is_copy_d = (cmd_op == OP_COPY);
          unique case (cmd_op)
            OP_READ, OP_COPY: begin
              state_d     = S_RD;
              rf_rd_sel_d = cmd_addr;
            end
            OP_WRITE: begin
              state_d      = S_WR;
              rf_wr_en_d   = ~acc_bad_c;
              rf_wr_sel_d  = cmd_addr;
              rf_data_in_d = cmd_data;
            end
            default: begin
              state_d      = S_CLR;
              cnt_d        = '0;
              rf_wr_en_d   = 1'b1;
              rf_wr_sel_d  = '0;
              rf_data_in_d = '0;
            end
          endcase
        end
      end
      S_RD: begin
        if (is_copy_q) begin
          state_d      = S_WR;
          rf_wr_en_d   = ~bad_q;
          rf_wr_sel_d  = dst_q;
          rf_data_in_d = rf_data_out;
        end else begin
          state_d    = S_RESP;
          rsp_data_d = bad_q ? '0 : rf_data_out;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        state_d = S_IDLE;
      end
      S_CLR: begin
        // Counter stops at the last register; it never wraps.
        if (cnt_q == SEL_W'(NUM_REGS - 1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d        = SEL_W'(cnt_q + 1'b1);
          rf_wr_en_d   = 1'b1;
          rf_wr_sel_d  = SEL_W'(cnt_q + 1'b1);
          rf_data_in_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign err        = err_q;
  assign rf_rd_sel  = rf_rd_sel_q;
  assign rf_wr_sel  = rf_wr_sel_q;
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_data_in = rf_data_in_q;

endmodule

// File: tb/tb_rf_master.sv
// Directed self-checking bench for rf_master with a behavioural 16-entry register file.
// Define RF_MASTER_ADDR_CHECK_EN to include the address-check steps.
module tb_rf_master;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned DATA_W   = 8;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [SEL_W-1:0]  cmd_addr;
  logic [SEL_W-1:0]  cmd_dst;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic              err;
  logic [SEL_W-1:0]  rf_rd_sel;
  logic [SEL_W-1:0]  rf_wr_sel;
  logic              rf_wr_en;
  logic [DATA_W-1:0] rf_data_in;
  logic [DATA_W-1:0] rf_data_out;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int c0;

  logic [DATA_W-1:0] mem [0:15];

  rf_master #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_dst(cmd_dst), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .err(err),
    .rf_rd_sel(rf_rd_sel), .rf_wr_sel(rf_wr_sel), .rf_wr_en(rf_wr_en),
    .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational read, write on rising edge.
  assign rf_data_out = mem[rf_rd_sel];
  always @(posedge clk) begin
    if (rf_wr_en) begin
      mem[rf_wr_sel] <= rf_data_in;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one command and return 1 time unit after its acceptance edge.
  task automatic do_cmd(input logic [1:0] op, input logic [SEL_W-1:0] addr,
                        input logic [SEL_W-1:0] dst, input logic [DATA_W-1:0] data);
    int n;
    @(negedge clk);
    cmd_op = op; cmd_addr = addr; cmd_dst = dst; cmd_data = data; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_dst = '0;
    cmd_data = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_wr_en", 32'(rf_wr_en), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_wr_en", 32'(rf_wr_en), 32'd0);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_err", 32'(err), 32'd0);

    // WRITE r3 = A5
    c0 = wr_cnt;
    do_cmd(OP_WRITE, 4'd3, 4'd0, 8'hA5);
    chk("wr_en", 32'(rf_wr_en), 32'd1);
    chk("wr_sel", 32'(rf_wr_sel), 32'd3);
    chk("wr_data", 32'(rf_data_in), 32'hA5);
    chk("wr_busy", 32'(busy), 32'd1);
    chk("wr_cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    chk("wr_en_done", 32'(rf_wr_en), 32'd0);
    chk("wr_ready_again", 32'(cmd_ready), 32'd1);
    chk("wr_pulse_count", 32'(wr_cnt - c0), 32'd1);

    // READ r3
    do_cmd(OP_READ, 4'd3, 4'd0, 8'h00);
    chk("rd_rsp_early", 32'(rsp_valid), 32'd0);
    chk("rd_sel", 32'(rf_rd_sel), 32'd3);
    step();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_data", 32'(rsp_data), 32'hA5);
    step();
    chk("rd_rsp_done", 32'(rsp_valid), 32'd0);
    chk("rd_ready_again", 32'(cmd_ready), 32'd1);

    // COPY r5 -> r1
    do_cmd(OP_WRITE, 4'd5, 4'd0, 8'h3C);
    step();
    c0 = wr_cnt;
    do_cmd(OP_COPY, 4'd5, 4'd1, 8'h00);
    chk("cp_no_wr_in_rd", 32'(rf_wr_en), 32'd0);
    chk("cp_rd_sel", 32'(rf_rd_sel), 32'd5);
    step();
    chk("cp_wr_en", 32'(rf_wr_en), 32'd1);
    chk("cp_wr_sel", 32'(rf_wr_sel), 32'd1);
    chk("cp_wr_data", 32'(rf_data_in), 32'h3C);
    step();
    chk("cp_wr_done", 32'(rf_wr_en), 32'd0);
    chk("cp_pulse_count", 32'(wr_cnt - c0), 32'd1);
    chk("cp_mem1", 32'(mem[1]), 32'h3C);
    chk("cp_no_rsp", 32'(rsp_valid), 32'd0);

    // READ r1 with backpressure
    rsp_ready = 1'b0;
    do_cmd(OP_READ, 4'd1, 4'd0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", 32'(rsp_data), 32'h3C);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_rsp_done", 32'(rsp_valid), 32'd0);
    chk("bp_ready_again", 32'(cmd_ready), 32'd1);

    // CLEAR after preload
    for (int i = 0; i < 8; i++) begin
      do_cmd(OP_WRITE, SEL_W'(i), 4'd0, DATA_W'((i + 1) * 17));
      step();
    end
    chk("pre_mem7", 32'(mem[7]), 32'h88);
    c0 = wr_cnt;
    do_cmd(OP_CLEAR, 4'd0, 4'd0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      chk("clr_wr_en", 32'(rf_wr_en), 32'd1);
      chk("clr_sel", 32'(rf_wr_sel), 32'(i));
      chk("clr_data", 32'(rf_data_in), 32'd0);
      step();
    end
    chk("clr_done_wr_en", 32'(rf_wr_en), 32'd0);
    chk("clr_done_ready", 32'(cmd_ready), 32'd1);
    chk("clr_write_count", 32'(wr_cnt - c0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      do_cmd(OP_READ, SEL_W'(i), 4'd0, 8'h00);
      step();
      chk("clr_rd_valid", 32'(rsp_valid), 32'd1);
      chk("clr_rd_data", 32'(rsp_data), 32'h00);
      step();
    end

    // Reset in the middle of CLEAR
    for (int i = 0; i < 8; i++) begin
      do_cmd(OP_WRITE, SEL_W'(i), 4'd0, DATA_W'((i + 1) * 17));
      step();
    end
    do_cmd(OP_CLEAR, 4'd0, 4'd0, 8'h00);
    repeat (3) step();
    chk("mid_clr_sel", 32'(rf_wr_sel), 32'd3);
    chk("mid_clr_wr_en", 32'(rf_wr_en), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_abort_wr_en", 32'(rf_wr_en), 32'd0);
    chk("rst_abort_busy", 32'(busy), 32'd0);
    chk("rst_abort_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_abort_ready_after", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) chk("rst_abort_cleared", 32'(mem[i]), 32'd0);
    for (int i = 3; i < 8; i++) chk("rst_abort_kept", 32'(mem[i]), 32'((i + 1) * 17));

`ifdef RF_MASTER_ADDR_CHECK_EN
    c0 = wr_cnt;
    do_cmd(OP_WRITE, 4'd9, 4'd0, 8'hFF);
    chk("ac_no_wr_en", 32'(rf_wr_en), 32'd0);
    chk("ac_err_set", 32'(err), 32'd1);
    step();
    chk("ac_no_wr_en2", 32'(rf_wr_en), 32'd0);
    chk("ac_wr_count", 32'(wr_cnt - c0), 32'd0);
    chk("ac_wr_ready", 32'(cmd_ready), 32'd1);
    do_cmd(OP_READ, 4'd12, 4'd0, 8'h00);
    step();
    chk("ac_rd_valid", 32'(rsp_valid), 32'd1);
    chk("ac_rd_data", 32'(rsp_data), 32'h00);
    step();
    chk("ac_err_sticky", 32'(err), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ac_err_reset", 32'(err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
`else
    chk("err_tied_low", 32'(err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
